// File: rtl/multicycle_control_pkg.sv
// Shared MIPS multicycle constants: state encodings, opcodes, mux selects and
// the per-state Moore output table used by the control FSM.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9
  } state_e;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       fetch;
    logic       decode;
    logic       branch;
    logic       jump;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.fetch     = 1'b1;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_IMM_SL2;
        c.decode    = 1'b1;
      end
      ST_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_SUB;
        c.pc_source = PCSRC_ALUOUT;
        c.branch    = 1'b1;
      end
      ST_JUMP: begin
        c.pc_source = PCSRC_JUMP;
        c.jump      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// (slave): instruction fields in, mux selects and enables out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, zero,
    output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal
  );

  modport slave (
    output opcode, zero,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal
  );
endinterface

// File: rtl/multicycle_control_wait_counter.sv
// Memory wait down-counter: loaded on state entry, done when it reaches zero.
module mc_wait_counter #(
  parameter logic [3:0] RESET_VALUE = '0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] value,
  output logic       done
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = value;
    else if (count_q != '0)
      count_d = count_q - 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count_q <= RESET_VALUE;
    else
      count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/multicycle_control.sv
// MIPS multicycle Moore control FSM with parameterised memory wait states.
// Build option: define MC_JUMP_EN to support the j instruction (JUMP state).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input logic                 clock,
  input logic                 reset,
  multicycle_control_if.master bus
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   bne_q, bne_d;
  logic   wait_load, wait_done;
  logic   op_legal;
  logic   pc_write;

  always_comb begin
    case (bus.opcode)
      OP_R, OP_BEQ, OP_BNE, OP_LW, OP_SW: op_legal = 1'b1;
`ifdef MC_JUMP_EN
      OP_J:                               op_legal = 1'b1;
`endif
      default:                            op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bne_d   = bne_q;
    case (state_q)
      ST_FETCH:    if (wait_done) state_d = ST_DECODE;
      ST_DECODE: begin
        bne_d = (bus.opcode == OP_BNE);
        case (bus.opcode)
          OP_R:          state_d = ST_EXECUTE;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_LW, OP_SW:  state_d = ST_MEMADR;
`ifdef MC_JUMP_EN
          OP_J:          state_d = ST_JUMP;
`endif
          default:       state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:   state_d = (bus.opcode == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  if (wait_done) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (wait_done) state_d = ST_FETCH;
      ST_EXECUTE:  state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
`ifdef MC_JUMP_EN
      ST_JUMP:     state_d = ST_FETCH;
`endif
      default:     state_d = ST_FETCH;
    endcase
    // Outputs are registered from the next state so they change with state_q.
    ctrl_d = state_ctrl(state_d);
    // Every state change reloads the counter; only memory states consume it.
    wait_load = (state_d != state_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ctrl_q  <= state_ctrl(ST_FETCH);
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      bne_q   <= bne_d;
    end
  end

  mc_wait_counter #(
    .RESET_VALUE(WAIT_INIT)
  ) u_wait (
    .clock (clock),
    .reset (reset),
    .load  (wait_load),
    .value (WAIT_INIT),
    .done  (wait_done)
  );

  assign pc_write = (ctrl_q.fetch & wait_done) | ctrl_q.jump;

  assign bus.pc_en      = ctrl_q.branch ? (bne_q ? ~bus.zero : bus.zero) : pc_write;
  assign bus.ir_write   = ctrl_q.fetch & wait_done;
  assign bus.illegal    = ctrl_q.decode & ~op_legal;
  assign bus.i_or_d     = ctrl_q.i_or_d;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.pc_source  = ctrl_q.pc_source;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: one instance with MEM_WAIT=0 and one
// with MEM_WAIT=3; expected per-cycle outputs are queued and checked at negedge.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, irw, rw, m2r, rdst, iord, asa;
    logic [1:0] asb, aop, pcs;
    logic       pcen, ill;
  } obs_t;

  typedef struct {
    obs_t  v;
    string nm;
  } exp_t;

  logic clock = 1'b0;
  logic rst0, rst1;
  always #5 clock = ~clock;

  multicycle_control_if bus0 ();
  multicycle_control_if bus1 ();

  multicycle_control #(.MEM_WAIT(0)) u_dut0 (.clock(clock), .reset(rst0), .bus(bus0));
  multicycle_control #(.MEM_WAIT(3)) u_dut1 (.clock(clock), .reset(rst1), .bus(bus1));

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  obs_t got0, got1;
  assign got0 = {bus0.state, bus0.mem_read, bus0.mem_write, bus0.ir_write, bus0.reg_write,
                 bus0.mem_to_reg, bus0.reg_dst, bus0.i_or_d, bus0.alu_src_a, bus0.alu_src_b,
                 bus0.alu_op, bus0.pc_source, bus0.pc_en, bus0.illegal};
  assign got1 = {bus1.state, bus1.mem_read, bus1.mem_write, bus1.ir_write, bus1.reg_write,
                 bus1.mem_to_reg, bus1.reg_dst, bus1.i_or_d, bus1.alu_src_a, bus1.alu_src_b,
                 bus1.alu_op, bus1.pc_source, bus1.pc_en, bus1.illegal};

  // Monitor: one expected entry per clock cycle while a queue holds work.
  always @(negedge clock) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      total++;
      if (got0 !== e.v) begin
        bad++;
        $display("FAIL dut0 %s: got %h want %h", e.nm, got0, e.v);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      total++;
      if (got1 !== e.v) begin
        bad++;
        $display("FAIL dut1 %s: got %h want %h", e.nm, got1, e.v);
      end
    end
  end

  // Per-state output table written from the state/output list.
  function automatic obs_t st_obs(input int st, input bit last, input bit pcen, input bit ill);
    obs_t o;
    o = '0;
    o.st   = 4'(st);
    o.pcen = pcen;
    o.ill  = ill;
    case (st)
      0: begin o.mr = 1'b1; o.asb = 2'b01; o.irw = last; end
      1: o.asb = 2'b11;
      2: begin o.asa = 1'b1; o.asb = 2'b10; end
      3: begin o.mr = 1'b1; o.iord = 1'b1; end
      4: begin o.rw = 1'b1; o.m2r = 1'b1; end
      5: begin o.mw = 1'b1; o.iord = 1'b1; end
      6: begin o.asa = 1'b1; o.aop = 2'b10; end
      7: begin o.rw = 1'b1; o.rdst = 1'b1; end
      8: begin o.asa = 1'b1; o.aop = 2'b01; o.pcs = 2'b01; end
      9: o.pcs = 2'b10;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input int d, input int st, input bit last, input bit pcen,
                      input bit ill, input string nm);
    exp_t e;
    e.v  = st_obs(st, last, pcen, ill);
    e.nm = nm;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // FETCH lasts mw+1 cycles; only the last one loads IR and enables the PC.
  task automatic fetch(input int d, input int mw, input string nm);
    for (int k = 0; k < mw; k++) push(d, 0, 1'b0, 1'b0, 1'b0, {nm, " fetch wait"});
    push(d, 0, 1'b1, 1'b1, 1'b0, {nm, " fetch last"});
  endtask

  task automatic set_in(input int d, input logic [5:0] op, input logic z);
    if (d == 0) begin bus0.opcode = op; bus0.zero = z; end
    else        begin bus1.opcode = op; bus1.zero = z; end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    set_in(0, 6'd0, 1'b0);
    set_in(1, 6'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1 rst0 = 1'b1;

    // MEM_WAIT=0 instance
    set_in(0, 6'd35, 1'b0); fetch(0, 0, "lw");
    push(0, 1, 0, 0, 0, "lw decode"); push(0, 2, 0, 0, 0, "lw memadr");
    push(0, 3, 0, 0, 0, "lw memread"); push(0, 4, 0, 0, 0, "lw memwb");
    step(5);

    set_in(0, 6'd43, 1'b0); fetch(0, 0, "sw");
    push(0, 1, 0, 0, 0, "sw decode"); push(0, 2, 0, 0, 0, "sw memadr");
    push(0, 5, 0, 0, 0, "sw memwrite");
    step(4);

    set_in(0, 6'd0, 1'b0); fetch(0, 0, "rtype");
    push(0, 1, 0, 0, 0, "rtype decode"); push(0, 6, 0, 0, 0, "rtype execute");
    push(0, 7, 0, 0, 0, "rtype aluwb");
    step(4);

    set_in(0, 6'd4, 1'b1); fetch(0, 0, "beq z1");
    push(0, 1, 0, 0, 0, "beq z1 decode"); push(0, 8, 0, 1, 0, "beq z1 branch");
    step(3);

    set_in(0, 6'd4, 1'b0); fetch(0, 0, "beq z0");
    push(0, 1, 0, 0, 0, "beq z0 decode"); push(0, 8, 0, 0, 0, "beq z0 branch");
    step(3);

    set_in(0, 6'd5, 1'b1); fetch(0, 0, "bne z1");
    push(0, 1, 0, 0, 0, "bne z1 decode"); push(0, 8, 0, 0, 0, "bne z1 branch");
    step(3);

    set_in(0, 6'd5, 1'b0); fetch(0, 0, "bne z0");
    push(0, 1, 0, 0, 0, "bne z0 decode"); push(0, 8, 0, 1, 0, "bne z0 branch");
    step(3);

    set_in(0, 6'd2, 1'b0); fetch(0, 0, "j");
`ifdef MC_JUMP_EN
    push(0, 1, 0, 0, 0, "j decode"); push(0, 9, 0, 1, 0, "j jump");
    step(3);
`else
    push(0, 1, 0, 0, 1, "j illegal decode");
    step(2);
`endif

    set_in(0, 6'd63, 1'b0); fetch(0, 0, "op63");
    push(0, 1, 0, 0, 1, "op63 illegal decode");
    step(2);

    set_in(0, 6'd0, 1'b0); fetch(0, 0, "after illegal");
    push(0, 1, 0, 0, 0, "after illegal decode");
    step(2);
    rst0 = 1'b0;

    // MEM_WAIT=3 instance
    rst1 = 1'b1;
    set_in(1, 6'd0, 1'b0); fetch(1, 3, "w3 rtype");
    push(1, 1, 0, 0, 0, "w3 rtype decode"); push(1, 6, 0, 0, 0, "w3 rtype execute");
    push(1, 7, 0, 0, 0, "w3 rtype aluwb");
    step(7);

    set_in(1, 6'd43, 1'b0); fetch(1, 3, "w3 sw");
    push(1, 1, 0, 0, 0, "w3 sw decode"); push(1, 2, 0, 0, 0, "w3 sw memadr");
    for (int k = 0; k < 4; k++) push(1, 5, 0, 0, 0, "w3 sw memwrite");
    step(10);

    // Abort a store in its second MEMWRITE cycle with an asynchronous reset.
    set_in(1, 6'd43, 1'b0); fetch(1, 3, "w3 sw abort");
    push(1, 1, 0, 0, 0, "w3 abort decode"); push(1, 2, 0, 0, 0, "w3 abort memadr");
    push(1, 5, 0, 0, 0, "w3 abort memwrite");
    step(7);
    #1 rst1 = 1'b0;
    push(1, 0, 0, 0, 0, "w3 in reset");
    step(1);
    rst1 = 1'b1;

    set_in(1, 6'd35, 1'b0); fetch(1, 3, "w3 lw post reset");
    push(1, 1, 0, 0, 0, "w3 lw decode"); push(1, 2, 0, 0, 0, "w3 lw memadr");
    for (int k = 0; k < 4; k++) push(1, 3, 0, 0, 0, "w3 lw memread");
    push(1, 4, 0, 0, 0, "w3 lw memwb");
    step(11);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
